tri_bus_arb: RTL

TRI_BUS_ARB -- requirements
Module: tri_bus_arb

---
 rtl/tri_bus_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/tri_bus_arb.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tri_bus_pkg.sv
// Shared arbiter types: FSM state encoding and the state-width constant.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package tri_bus_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Index width for n requesters; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit strictly after ptr, wrapping modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the pick.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Walk ptr+1 .. ptr+N (mod N), so the last owner gets the lowest priority.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        pick[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arb.sv
// Tristate bus arbiter: round-robin one-hot grant, turnaround gap, park-level monitor.
// Latency: grant 1 cycle after a request seen in IDLE; release 1 cycle after owner req drops.
// Backpressure: owner keeps the bus while req is held; others wait. Macro TRI_BUS_ARB_TIMEOUT_EN adds a hold limit.
module tri_bus_arb
  import tri_bus_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int W         = 8,
  parameter  int TURN_CYC  = 1,
  parameter  int HOLD_MAX  = 16,
  parameter  int PARK_HIGH = 1,
  localparam int OW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     bus_in,
  output logic [N_REQ-1:0] gnt,
  output logic [OW-1:0]    owner,
  output logic             busy,
  output logic             timeout,
  output logic             park_err
);

  localparam logic [W-1:0] PARK_VAL  = (PARK_HIGH != 0) ? {W{1'b1}} : {W{1'b0}};
  localparam logic [2:0]   TURN_LAST = 3'(TURN_CYC - 1);

  state_t           state;
  logic [OW-1:0]    rr_ptr;
  logic [2:0]       turn_cnt;
  logic [N_REQ-1:0] pick_oh;
  logic [OW-1:0]    pick_idx;
  logic             pick_any;
  logic             hold_hit;
  logic             park_chk;

  rr_pick #(
    .N  (N_REQ),
    .IW (OW)
  ) u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .pick (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // The first TURN cycle is skipped: the old owner's driver may still be releasing.
  always_comb begin
    park_chk = (state == IDLE) || ((state == TURN) && (turn_cnt != 3'd0));
  end

`ifdef TRI_BUS_ARB_TIMEOUT_EN
  localparam int HCW = $clog2(HOLD_MAX + 1);

  logic [HCW-1:0] hold_cnt;

  // Hold limit reached on the last allowed GRANT cycle.
  always_comb begin
    hold_hit = (state == GRANT) && (hold_cnt == HCW'(HOLD_MAX - 1));
  end

  // Count consecutive GRANT cycles; flag a release forced while the owner still wanted the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout  <= hold_hit && req[owner];
      hold_cnt <= (state == GRANT) ? hold_cnt + 1'b1 : '0;
    end
  end
`else
  // No hold limit: the owner keeps the bus for as long as it requests it.
  always_comb begin
    hold_hit = 1'b0;
  end

  assign timeout = 1'b0;
`endif

  // Arbitration FSM with registered grant, owner and busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      park_err <= 1'b0;
      rr_ptr   <= OW'(N_REQ - 1);
      turn_cnt <= '0;
    end else begin
      if (park_chk && (bus_in != PARK_VAL)) begin
        park_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pick_any) begin
            state  <= GRANT;
            gnt    <= pick_oh;
            owner  <= pick_idx;
            rr_ptr <= pick_idx;
            busy   <= 1'b1;
          end
        end
        GRANT: begin
          if (!req[owner] || hold_hit) begin
            state    <= TURN;
            gnt      <= '0;
            busy     <= 1'b0;
            turn_cnt <= '0;
          end
        end
        TURN: begin
          if (turn_cnt == TURN_LAST) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
